seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
//
// PURPOSE
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//   Accepts a hex value, decimal points and a digit-enable mask through a valid/ready
//   handshake. Buffers one pending update and applies it only at a frame boundary, so
//   the display never tears. Drives active-low anodes and segments with a blanking gap
//   between digits to suppress ghosting. Sits between user logic and the board pins.
//
// PARAMETERS
//   N_DIGITS      4       number of digits scanned (>=1)
//   TICK_DIV      100000  clk cycles per digit slot (>=2)
//   BLANK_CYCLES  1000    cycles at slot start with all anodes off (0 <= BLANK_CYCLES < TICK_DIV)
//
// PORTS
//   clk           in   1             system clock; all logic on the rising edge
//   rst           in   1             synchronous reset, active-high
//   value_in      in   4*N_DIGITS    hex nibbles; digit i = value_in[4i+3:4i], digit 0 = rightmost
//   dp_in         in   N_DIGITS      decimal point per digit, 1 = lit
//   digit_en_in   in   N_DIGITS      1 = digit shown, 0 = digit dark
//   update_valid  in   1             update offered on value_in/dp_in/digit_en_in
//   update_ready  out  1             pending buffer empty; update accepted when valid&&ready
//   an_n          out  N_DIGITS      anode enables, active-low, at most one low at any time
//   seg_n         out  7             segments {g,f,e,d,c,b,a}, active-low, seg_n[0]=a
//   dp_n          out  1             decimal point, active-low
//   frame_done    out  1             1-cycle pulse at each digit N-1 -> 0 wrap
//
// BEHAVIOUR
//   Reset: an_n all 1, seg_n 7'h7F, dp_n 1, frame_done 0, update_ready 1, slot_cnt 0,
//     digit index 0, display regs (value/dp/en) all 0, pending empty. Reset mid-frame
//     aborts the scan and discards any pending update.
//   Counters: slot_cnt runs 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and the digit
//     index advances d -> d+1, wrapping N_DIGITS-1 -> 0.
//   FSM per slot: BLANK while slot_cnt < BLANK_CYCLES (an_n all 1, seg_n 7'h7F, dp_n 1);
//     ON otherwise. All outputs are registered and reflect the current slot_cnt/index.
//   In ON: an_n[d]=0 and seg_n = decode(display nibble d), dp_n = ~dp[d], only when
//     en[d]=1. If en[d]=0, the slot behaves as BLANK for its whole duration.
//   Decode (active-low, {g..a}): 0 1000000, 1 1111001, 2 0100100, 3 0110000,
//     4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000,
//     b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
//   Handshake: update_ready = pending empty (a registered flag). On valid&&ready, the
//     pending buffer captures value/dp/en and update_ready drops on the next cycle.
//     update_valid while ready=0 is ignored; the sender holds the update.
//   Frame boundary: on the edge where index wraps N_DIGITS-1 -> 0, frame_done pulses
//     for 1 cycle. If pending is full (pre-edge state), it is copied to the display
//     regs, pending is cleared, and update_ready returns to 1.
//   Simultaneous accept and wrap with pending empty: the update is stored as pending
//     and applied at the NEXT wrap, not the current one.
//   Latency: an accepted update is first visible in the digit-0 slot after the next
//     wrap; worst case N_DIGITS*TICK_DIV + 1 cycles after accept.
//   N_DIGITS=1: index is constant 0, and every slot end is a wrap.
//
// TESTING  (N_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2 unless noted)
//   1 Reset held 3 cycles, then released -> an_n=4'hF, seg_n=7'h7F, dp_n=1, update_ready=1;
//     first frame_done exactly 32 cycles after reset release.
//   2 Send update 16'h1234, en=4'hF -> each slot has 2 dark cycles, then 6 cycles with the
//     digit's anode low, in order an_n=E,D,B,7; digit 0 shows seg_n=0011001 ("4").
//   3 Assert update_valid mid-frame -> ready=0 on the next cycle; the old value is shown
//     until the wrap; at the wrap, the new value loads and ready=1; a second valid while
//     ready=0 is not captured.
//   4 Accept an update on the exact wrap edge with pending empty -> the old value is shown
//     for one more full frame; the new value appears after the following frame_done.
//   5 Set en=4'b0101, dp=4'b0001 -> an_n never goes low for digits 1 and 3; dp_n=0 only
//     in the digit-0 ON window; an_n is never more than one-hot low (assertion).
//   6 Assert rst during the digit-2 ON window with an update pending -> outputs return to
//     reset values on the next edge; pending is dropped; the display shows all-zero
//     value with en=0, so it stays dark.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Updates are buffered through a one-deep pending slot and committed only at frame wrap.
module seven_seg_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en_in,
    input  logic                    update_valid,
    output logic                    update_ready,
    output logic [N_DIGITS-1:0]     an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    state_t                  state_r;
    logic [CW-1:0]           slot_cnt_r;
    logic [IW-1:0]           idx_r;
    logic [4*N_DIGITS-1:0]   disp_value_r;
    logic [N_DIGITS-1:0]     disp_dp_r;
    logic [N_DIGITS-1:0]     disp_en_r;
    logic [4*N_DIGITS-1:0]   pend_value_r;
    logic [N_DIGITS-1:0]     pend_dp_r;
    logic [N_DIGITS-1:0]     pend_en_r;
    logic                    pend_full_r;
    logic                    update_ready_r;
    logic [N_DIGITS-1:0]     an_n_r;
    logic [6:0]              seg_n_r;
    logic                    dp_n_r;
    logic                    frame_done_r;

    logic                    slot_end_s;
    logic                    wrap_s;
    logic                    accept_s;
    logic                    load_s;
    logic [CW-1:0]           slot_nx_s;
    logic [IW-1:0]           idx_nx_s;
    logic [4*N_DIGITS-1:0]   disp_value_nx_s;
    logic [N_DIGITS-1:0]     disp_dp_nx_s;
    logic [N_DIGITS-1:0]     disp_en_nx_s;
    logic                    pend_full_nx_s;
    logic [3:0]              nib_sel_s;
    logic                    dp_sel_s;
    logic                    en_sel_s;
    logic [N_DIGITS-1:0]     an_on_s;
    state_t                  state_nx_s;

    // Counter advance, handshake and frame-boundary commit decisions.
    always_comb begin
        slot_end_s = (slot_cnt_r == SLOT_LAST);
        wrap_s     = slot_end_s && (idx_r == IDX_LAST);
        accept_s   = update_valid && update_ready_r;
        load_s     = wrap_s && pend_full_r;

        if (slot_end_s) begin
            slot_nx_s = {CW{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_nx_s = {IW{1'b0}};
            end else begin
                idx_nx_s = idx_r + IW'(1);
            end
        end else begin
            slot_nx_s = slot_cnt_r + CW'(1);
            idx_nx_s  = idx_r;
        end

        if (load_s) begin
            disp_value_nx_s = pend_value_r;
            disp_dp_nx_s    = pend_dp_r;
            disp_en_nx_s    = pend_en_r;
        end else begin
            disp_value_nx_s = disp_value_r;
            disp_dp_nx_s    = disp_dp_r;
            disp_en_nx_s    = disp_en_r;
        end

        // Accept only happens while empty and load only while full, so they never collide.
        if (accept_s) begin
            pend_full_nx_s = 1'b1;
        end else if (load_s) begin
            pend_full_nx_s = 1'b0;
        end else begin
            pend_full_nx_s = pend_full_r;
        end
    end

    // Select the digit that the next cycle will present, from the post-commit display regs.
    always_comb begin
        nib_sel_s = 4'h0;
        dp_sel_s  = 1'b0;
        en_sel_s  = 1'b0;
        an_on_s   = {N_DIGITS{1'b1}};
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IW'(i) == idx_nx_s) begin
                nib_sel_s  = disp_value_nx_s[4*i +: 4];
                dp_sel_s   = disp_dp_nx_s[i];
                en_sel_s   = disp_en_nx_s[i];
                an_on_s[i] = 1'b0;
            end else begin
                an_on_s[i] = 1'b1;
            end
        end

        if ((slot_nx_s >= BLANK_END) && en_sel_s) begin
            state_nx_s = ST_ON;
        end else begin
            state_nx_s = ST_BLANK;
        end
    end

    // Scan FSM, counters, buffers and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_BLANK;
            slot_cnt_r     <= {CW{1'b0}};
            idx_r          <= {IW{1'b0}};
            disp_value_r   <= {(4*N_DIGITS){1'b0}};
            disp_dp_r      <= {N_DIGITS{1'b0}};
            disp_en_r      <= {N_DIGITS{1'b0}};
            pend_value_r   <= {(4*N_DIGITS){1'b0}};
            pend_dp_r      <= {N_DIGITS{1'b0}};
            pend_en_r      <= {N_DIGITS{1'b0}};
            pend_full_r    <= 1'b0;
            update_ready_r <= 1'b1;
            an_n_r         <= {N_DIGITS{1'b1}};
            seg_n_r        <= 7'h7F;
            dp_n_r         <= 1'b1;
            frame_done_r   <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            slot_cnt_r     <= slot_nx_s;
            idx_r          <= idx_nx_s;
            disp_value_r   <= disp_value_nx_s;
            disp_dp_r      <= disp_dp_nx_s;
            disp_en_r      <= disp_en_nx_s;
            pend_full_r    <= pend_full_nx_s;
            update_ready_r <= !pend_full_nx_s;
            frame_done_r   <= wrap_s;
            if (accept_s) begin
                pend_value_r <= value_in;
                pend_dp_r    <= dp_in;
                pend_en_r    <= digit_en_in;
            end else begin
                pend_value_r <= pend_value_r;
                pend_dp_r    <= pend_dp_r;
                pend_en_r    <= pend_en_r;
            end
            case (state_nx_s)
                ST_ON: begin
                    an_n_r  <= an_on_s;
                    seg_n_r <= hex_to_seg_n(nib_sel_s);
                    dp_n_r  <= !dp_sel_s;
                end
                ST_BLANK: begin
                    an_n_r  <= {N_DIGITS{1'b1}};
                    seg_n_r <= 7'h7F;
                    dp_n_r  <= 1'b1;
                end
                default: begin
                    an_n_r  <= {N_DIGITS{1'b1}};
                    seg_n_r <= 7'h7F;
                    dp_n_r  <= 1'b1;
                end
            endcase
        end
    end

    assign update_ready = update_ready_r;
    assign an_n         = an_n_r;
    assign seg_n        = seg_n_r;
    assign dp_n         = dp_n_r;
    assign frame_done   = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: cycle-count reference model, table of update vectors,
// hand-written corner sequences and a randomized soak.
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int T  = 8;
    localparam int B  = 2;
    localparam int FR = N * T;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   value_in;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en_in;
    logic          update_valid;
    logic          update_ready;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          frame_done;

    seven_seg_scan_ctrl #(.N_DIGITS(N), .TICK_DIV(T), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in),
        .digit_en_in(digit_en_in), .update_valid(update_valid),
        .update_ready(update_ready), .an_n(an_n), .seg_n(seg_n),
        .dp_n(dp_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int n_vec = 0;
    int n_bad = 0;

    // reference model: a plain cycle count since reset plus shadow buffers
    int          m_cyc;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, p_dp, m_en, p_en;
    logic        m_pf, m_fd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic acc;
        if (rst) begin
            m_cyc = 0; m_val = 16'h0; m_dp = 4'h0; m_en = 4'h0;
            p_val = 16'h0; p_dp = 4'h0; p_en = 4'h0; m_pf = 1'b0; m_fd = 1'b0;
        end else begin
            acc  = update_valid && !m_pf;
            m_fd = ((m_cyc % FR) == FR - 1);
            if (m_fd && m_pf) begin
                m_val = p_val; m_dp = p_dp; m_en = p_en; m_pf = 1'b0;
            end
            if (acc) begin
                p_val = value_in; p_dp = dp_in; p_en = digit_en_in; m_pf = 1'b1;
            end
            m_cyc++;
        end
    endtask

    task automatic check_all();
        int   slot, dig;
        logic on;
        logic [3:0] nib;
        slot = m_cyc % T;
        dig  = (m_cyc / T) % N;
        on   = (slot >= B) && m_en[dig];
        nib  = 4'((m_val >> (4 * dig)) & 16'hF);
        chk("an_n",  {28'h0, an_n},  on ? {28'h0, 4'hF & ~(4'h1 << dig)} : 32'hF);
        chk("seg_n", {25'h0, seg_n}, on ? {25'h0, dec[nib]} : 32'h7F);
        chk("dp_n",  {31'h0, dp_n},  on ? {31'h0, !m_dp[dig]} : 32'h1);
        chk("frame_done",   {31'h0, frame_done},   {31'h0, m_fd});
        chk("update_ready", {31'h0, update_ready}, {31'h0, !m_pf});
        chk("an_onehot", {31'h0, ($countones(~an_n) <= 1)}, 32'h1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to(input int pos);
        int k = 0;
        while ((m_cyc % FR) != pos && k < 2 * FR) begin
            cycle();
            k++;
        end
        if ((m_cyc % FR) != pos) chk("run_to_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_frame();
        logic seen = 1'b0;
        for (int i = 0; i < 3 * FR && !seen; i++) begin
            cycle();
            seen = frame_done;
        end
        if (!seen) chk("frame_timeout", 32'h0, 32'h1);
    endtask

    task automatic apply_update(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        logic ok = 1'b0;
        logic rdy;
        value_in = v; dp_in = d; digit_en_in = e; update_valid = 1'b1;
        for (int i = 0; i < 3 * FR && !ok; i++) begin
            rdy = !m_pf;
            cycle();
            ok = rdy;
        end
        update_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp_n;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] an_order[4];
    int   cnt, dark_hits, dp_hits;

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'hF,    4'hE, 7'b0011001, 1'b1};
        vecs[1] = '{16'h00AB, 4'b0001, 4'hF,    4'hE, 7'b0000011, 1'b0};
        vecs[2] = '{16'hFFF0, 4'b1111, 4'b1110, 4'hF, 7'h7F,      1'b1};
        vecs[3] = '{16'h0008, 4'b0001, 4'b0001, 4'hE, 7'b0000000, 1'b0};
        vecs[4] = '{16'h555C, 4'b0000, 4'hF,    4'hE, 7'b1000110, 1'b1};
        vecs[5] = '{16'h000E, 4'b0010, 4'b0011, 4'hE, 7'b0000110, 1'b1};
        an_order[0] = 4'hE; an_order[1] = 4'hD; an_order[2] = 4'hB; an_order[3] = 4'h7;

        rst = 1'b1; value_in = 16'h0; dp_in = 4'h0; digit_en_in = 4'h0; update_valid = 1'b0;
        run(3);
        chk("rst_an_n",  {28'h0, an_n},  32'hF);
        chk("rst_seg_n", {25'h0, seg_n}, 32'h7F);
        chk("rst_ready", {31'h0, update_ready}, 32'h1);
        rst = 1'b0;

        // first frame_done exactly 32 cycles after release
        cnt = 0;
        for (int i = 1; i <= 40 && cnt == 0; i++) begin
            cycle();
            if (frame_done) cnt = i;
        end
        chk("first_frame_done", cnt, 32'd32);

        // 1234 all enabled: dark head then anode order E,D,B,7
        apply_update(16'h1234, 4'h0, 4'hF);
        wait_frame();
        for (int d = 0; d < N; d++) begin
            run_to(d * T + 1);
            chk("slot_dark", {28'h0, an_n}, 32'hF);
            run_to(d * T + 4);
            chk("an_order", {28'h0, an_n}, {28'h0, an_order[d]});
        end

        for (int v = 0; v < 6; v++) begin
            apply_update(vecs[v].val, vecs[v].dp, vecs[v].en);
            wait_frame();
            run(2);
            chk("tbl_an_n",  {28'h0, an_n},  {28'h0, vecs[v].exp_an});
            chk("tbl_seg_n", {25'h0, seg_n}, {25'h0, vecs[v].exp_seg});
            chk("tbl_dp_n",  {31'h0, dp_n},  {31'h0, vecs[v].exp_dp_n});
        end

        // mid-frame accept, second offer while not ready is ignored
        run_to(10);
        apply_update(16'h0009, 4'h0, 4'hF);
        chk("ready_drop", {31'h0, update_ready}, 32'h0);
        value_in = 16'h0001; update_valid = 1'b1;
        run(5);
        update_valid = 1'b0;
        wait_frame();
        chk("ready_at_wrap", {31'h0, update_ready}, 32'h1);
        run(2);
        chk("mid_new_seg", {25'h0, seg_n}, {25'h0, 7'b0010000});

        // accept on the exact wrap edge: applied one frame later
        run_to(FR - 1);
        value_in = 16'h0007; dp_in = 4'h0; digit_en_in = 4'hF; update_valid = 1'b1;
        cycle();
        update_valid = 1'b0;
        chk("wrap_acc_fd", {31'h0, frame_done}, 32'h1);
        chk("wrap_acc_ready", {31'h0, update_ready}, 32'h0);
        run(2);
        chk("wrap_old_seg", {25'h0, seg_n}, {25'h0, 7'b0010000});
        wait_frame();
        run(2);
        chk("wrap_new_seg", {25'h0, seg_n}, {25'h0, 7'b1111000});

        // sparse enables: digits 1 and 3 dark, dp only in digit-0 ON window
        apply_update(16'h4321, 4'b0001, 4'b0101);
        wait_frame();
        dark_hits = 0; dp_hits = 0;
        for (int i = 0; i < FR; i++) begin
            cycle();
            if (!an_n[1] || !an_n[3]) dark_hits++;
            if (!dp_n) dp_hits++;
        end
        chk("masked_digits_dark", dark_hits, 32'd0);
        chk("dp_window_len", dp_hits, 32'(T - B));

        // reset in digit-2 ON with pending update
        run_to(1);
        apply_update(16'hABCD, 4'hF, 4'hF);
        run_to(2 * T + 3);
        rst = 1'b1;
        cycle();
        chk("rst6_an_n",  {28'h0, an_n},  32'hF);
        chk("rst6_seg_n", {25'h0, seg_n}, 32'h7F);
        chk("rst6_dp_n",  {31'h0, dp_n},  32'h1);
        chk("rst6_ready", {31'h0, update_ready}, 32'h1);
        rst = 1'b0;
        dark_hits = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            cycle();
            if (an_n != 4'hF) dark_hits++;
        end
        chk("rst6_stays_dark", dark_hits, 32'd0);

        // randomized soak against the model
        for (int i = 0; i < 1500; i++) begin
            value_in     = 16'($urandom);
            dp_in        = 4'($urandom);
            digit_en_in  = 4'($urandom);
            update_valid = ($urandom_range(0, 5) == 0);
            rst          = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 1'b0; update_valid = 1'b0;
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
